apb_spi_mailbox: RTL and testbench

- APB slave that sits directly downstream of the SPI slave's APB master port.
- Terminates the APB transactions issued from SPI and provides a byte mailbox between the SPI host and the local host logic.
- Contains two FIFOs:
  - SPI-to-host FIFO (S2H): filled by APB writes, drained by local logic.
  - Host-to-SPI FIFO (H2S): filled by local logic, drained by APB reads.
- Also provides a control/status/scratch register set, a programmable wait-state generator and a level interrupt.

---
 rtl/apb_spi_mailbox.sv | 149 ++++++++++++++
 tb/tb_apb_spi_mailbox.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_spi_mailbox.sv
// APB slave behind the SPI bridge: byte mailbox with two FIFOs, control/status/scratch
// registers, programmable wait states and a registered level interrupt.
module apb_spi_mailbox #(
   parameter int APB_ADDR_WIDTH = 12,
   parameter int APB_DATA_WIDTH = 8,
   parameter int FIFO_LOG_DEPTH = 2,
   parameter int WAIT_CYCLES    = 1
) (
   input  logic                      apb_pclk_i,
   input  logic                      apb_preset_ni,
   input  logic                      psel_i,
   input  logic                      penable_i,
   input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
   input  logic                      pwrite_i,
   input  logic [APB_DATA_WIDTH-1:0] pwdata_i,
   output logic [APB_DATA_WIDTH-1:0] prdata_o,
   output logic                      pready_o,
   output logic [APB_DATA_WIDTH-1:0] host_rx_data_o,
   output logic                      host_rx_valid_o,
   input  logic                      host_rx_ready_i,
   input  logic [APB_DATA_WIDTH-1:0] host_tx_data_i,
   input  logic                      host_tx_valid_i,
   output logic                      host_tx_ready_o,
   output logic                      irq_o
);

   localparam int DEPTH = 1 << FIFO_LOG_DEPTH;
   localparam logic [3:0] WAIT_LIM = 4'(WAIT_CYCLES);
   localparam logic [APB_ADDR_WIDTH-1:0] ADDR_CTRL    = APB_ADDR_WIDTH'(0);
   localparam logic [APB_ADDR_WIDTH-1:0] ADDR_STATUS  = APB_ADDR_WIDTH'(1);
   localparam logic [APB_ADDR_WIDTH-1:0] ADDR_S2H     = APB_ADDR_WIDTH'(2);
   localparam logic [APB_ADDR_WIDTH-1:0] ADDR_H2S     = APB_ADDR_WIDTH'(3);
   localparam logic [APB_ADDR_WIDTH-1:0] ADDR_SCRATCH = APB_ADDR_WIDTH'(4);

   typedef logic [FIFO_LOG_DEPTH:0] ptr_t;

   function automatic logic ptr_full(input ptr_t w, input ptr_t r);
      return (w[FIFO_LOG_DEPTH] != r[FIFO_LOG_DEPTH]) &&
             (w[FIFO_LOG_DEPTH-1:0] == r[FIFO_LOG_DEPTH-1:0]);
   endfunction

   logic [3:0] wcnt;
   logic       irq_en, flush_s2h_q, flush_h2s_q, s2h_ovf, h2s_unf;
   logic [APB_DATA_WIDTH-1:0] scratch;
   ptr_t s2h_wptr, s2h_rptr, h2s_wptr, h2s_rptr;
   logic [APB_DATA_WIDTH-1:0] s2h_mem [DEPTH];
   logic [APB_DATA_WIDTH-1:0] h2s_mem [DEPTH];

   logic wr_commit, rd_commit;
   logic sel_ctrl, sel_status, sel_s2h, sel_h2s, sel_scratch;
   logic s2h_empty, s2h_full, h2s_empty, h2s_full;
   logic s2h_push, s2h_pop, h2s_push, h2s_pop, ovf_set, unf_set, ovf_clr, unf_clr;

   assign pready_o  = psel_i & penable_i & (wcnt == WAIT_LIM);
   assign wr_commit = pready_o & pwrite_i;
   assign rd_commit = pready_o & ~pwrite_i;

   assign sel_ctrl    = (paddr_i == ADDR_CTRL);
   assign sel_status  = (paddr_i == ADDR_STATUS);
   assign sel_s2h     = (paddr_i == ADDR_S2H);
   assign sel_h2s     = (paddr_i == ADDR_H2S);
   assign sel_scratch = (paddr_i == ADDR_SCRATCH);

   assign s2h_empty = (s2h_wptr == s2h_rptr);
   assign s2h_full  = ptr_full(s2h_wptr, s2h_rptr);
   assign h2s_empty = (h2s_wptr == h2s_rptr);
   assign h2s_full  = ptr_full(h2s_wptr, h2s_rptr);

   // Full/empty come from registered pointers, so a same-cycle host pop never rescues an overflow.
   assign s2h_push = wr_commit & sel_s2h & ~s2h_full;
   assign ovf_set  = wr_commit & sel_s2h & s2h_full;
   assign s2h_pop  = host_rx_ready_i & ~s2h_empty;
   assign h2s_push = host_tx_valid_i & ~h2s_full;
   assign h2s_pop  = rd_commit & sel_h2s & ~h2s_empty;
   assign unf_set  = rd_commit & sel_h2s & h2s_empty;
   assign ovf_clr  = wr_commit & sel_status & pwdata_i[4];
   assign unf_clr  = wr_commit & sel_status & pwdata_i[5];

   assign host_rx_data_o  = s2h_mem[s2h_rptr[FIFO_LOG_DEPTH-1:0]];
   assign host_rx_valid_o = ~s2h_empty;
   assign host_tx_ready_o = ~h2s_full;

   always_ff @(posedge apb_pclk_i or negedge apb_preset_ni) begin
      if (!apb_preset_ni) begin
         wcnt        <= '0;
         irq_en      <= 1'b0;
         flush_s2h_q <= 1'b0;
         flush_h2s_q <= 1'b0;
         s2h_ovf     <= 1'b0;
         h2s_unf     <= 1'b0;
         scratch     <= '0;
         irq_o       <= 1'b0;
      end else begin
         wcnt        <= (psel_i & penable_i & ~pready_o) ? wcnt + 4'd1 : 4'd0;
         flush_s2h_q <= wr_commit & sel_ctrl & pwdata_i[1];
         flush_h2s_q <= wr_commit & sel_ctrl & pwdata_i[2];
         if (wr_commit & sel_ctrl)    irq_en  <= pwdata_i[0];
         if (wr_commit & sel_scratch) scratch <= pwdata_i;
         s2h_ovf <= ovf_set | (s2h_ovf & ~ovf_clr);
         h2s_unf <= unf_set | (h2s_unf & ~unf_clr);
         irq_o   <= irq_en & (~s2h_empty | s2h_ovf | h2s_unf);
      end
   end

   // A pending flush overrides any push or pop in the same cycle.
   always_ff @(posedge apb_pclk_i or negedge apb_preset_ni) begin
      if (!apb_preset_ni) begin
         s2h_wptr <= '0;
         s2h_rptr <= '0;
      end else if (flush_s2h_q) begin
         s2h_rptr <= s2h_wptr;
      end else begin
         if (s2h_push) s2h_wptr <= s2h_wptr + ptr_t'(1);
         if (s2h_pop)  s2h_rptr <= s2h_rptr + ptr_t'(1);
      end
   end

   always_ff @(posedge apb_pclk_i or negedge apb_preset_ni) begin
      if (!apb_preset_ni) begin
         h2s_wptr <= '0;
         h2s_rptr <= '0;
      end else if (flush_h2s_q) begin
         h2s_rptr <= h2s_wptr;
      end else begin
         if (h2s_push) h2s_wptr <= h2s_wptr + ptr_t'(1);
         if (h2s_pop)  h2s_rptr <= h2s_rptr + ptr_t'(1);
      end
   end

   always_ff @(posedge apb_pclk_i) begin
      if (s2h_push) s2h_mem[s2h_wptr[FIFO_LOG_DEPTH-1:0]] <= pwdata_i;
      if (h2s_push) h2s_mem[h2s_wptr[FIFO_LOG_DEPTH-1:0]] <= host_tx_data_i;
   end

   always_comb begin
      prdata_o = '0;
      if (rd_commit) begin
         if (sel_ctrl)
            prdata_o = APB_DATA_WIDTH'(irq_en);
         else if (sel_status)
            prdata_o = APB_DATA_WIDTH'({h2s_unf, s2h_ovf, h2s_full, h2s_empty, s2h_full, s2h_empty});
         else if (sel_h2s && !h2s_empty)
            prdata_o = h2s_mem[h2s_rptr[FIFO_LOG_DEPTH-1:0]];
         else if (sel_scratch)
            prdata_o = scratch;
      end
   end

endmodule

// File: tb/tb_apb_spi_mailbox.sv
// Directed bench for apb_spi_mailbox (default parameters: 12-bit address, 8-bit data, depth 4, 1 wait state).
module tb_apb_spi_mailbox;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        psel, penable, pwrite;
   logic [11:0] paddr;
   logic [7:0]  pwdata, prdata;
   logic        pready;
   logic [7:0]  rx_data;
   logic        rx_valid, rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid, tx_ready;
   logic        irq;

   int checks   = 0;
   int failures = 0;

   apb_spi_mailbox dut (
      .apb_pclk_i     (clk),
      .apb_preset_ni  (rst_n),
      .psel_i         (psel),
      .penable_i      (penable),
      .paddr_i        (paddr),
      .pwrite_i       (pwrite),
      .pwdata_i       (pwdata),
      .prdata_o       (prdata),
      .pready_o       (pready),
      .host_rx_data_o (rx_data),
      .host_rx_valid_o(rx_valid),
      .host_rx_ready_i(rx_ready),
      .host_tx_data_i (tx_data),
      .host_tx_valid_i(tx_valid),
      .host_tx_ready_o(tx_ready),
      .irq_o          (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Entered and left at 1 time unit after a rising edge.
   task automatic apb(input logic [11:0] a, input logic w, input logic [7:0] d,
                      output logic [7:0] rd, output int cyc);
      int  n;
      logic done;
      rd = 8'h00; cyc = -1; done = 1'b0; n = 0;
      psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d;
      @(posedge clk); #1;
      penable = 1'b1;
      while (!done && n < 20) begin
         #3;
         if (pready) begin
            rd = prdata; cyc = n; done = 1'b1;
         end else begin
            @(posedge clk); #1;
            n++;
         end
      end
      if (!done) check("apb_timeout", {31'd0, done}, 32'd1);
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_wr(input logic [11:0] a, input logic [7:0] d);
      logic [7:0] rd;
      int cyc;
      apb(a, 1'b1, d, rd, cyc);
   endtask

   task automatic apb_rd(input logic [11:0] a, output logic [7:0] rd);
      int cyc;
      apb(a, 1'b0, 8'h00, rd, cyc);
   endtask

   task automatic host_pop();
      rx_ready = 1'b1;
      @(posedge clk); #1;
      rx_ready = 1'b0;
   endtask

   task automatic host_push(input logic [7:0] d);
      tx_valid = 1'b1; tx_data = d;
      @(posedge clk); #1;
      tx_valid = 1'b0;
   endtask

   initial begin
      logic [7:0] rd;
      int cyc;
      rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; rx_ready = 1'b0; tx_valid = 1'b0; tx_data = '0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_prdata", prdata, 8'h00);
      check("rst_pready", pready, 1'b0);
      check("rst_rx_valid", rx_valid, 1'b0);
      check("rst_tx_ready", tx_ready, 1'b1);
      check("rst_irq", irq, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // STATUS read: one wait state, both FIFOs empty
      apb(12'h001, 1'b0, 8'h00, rd, cyc);
      check("status_wait_cycles", cyc, 1);
      check("status_reset", rd, 8'h05);
      check("tx_ready_idle", tx_ready, 1'b1);

      // S2H ordering and host drain
      apb_wr(12'h002, 8'hA5);
      apb_wr(12'h002, 8'h3C);
      check("s2h_valid", rx_valid, 1'b1);
      check("s2h_head0", rx_data, 8'hA5);
      host_pop();
      check("s2h_head1", rx_data, 8'h3C);
      host_pop();
      check("s2h_drained", rx_valid, 1'b0);

      // S2H overflow: fifth byte dropped, sticky flag, W1C
      for (int i = 1; i <= 5; i++) apb_wr(12'h002, 8'(i));
      apb_rd(12'h001, rd);
      check("status_ovf", rd, 8'h16);
      apb_wr(12'h001, 8'h10);
      apb_rd(12'h001, rd);
      check("status_ovf_clr", rd, 8'h06);
      for (int i = 1; i <= 4; i++) begin
         check("s2h_ovf_order", rx_data, 32'(i));
         host_pop();
      end
      check("s2h_ovf_empty", rx_valid, 1'b0);

      // H2S read path and underflow
      host_push(8'h11);
      host_push(8'h22);
      apb_rd(12'h003, rd);
      check("h2s_rd0", rd, 8'h11);
      apb_rd(12'h003, rd);
      check("h2s_rd1", rd, 8'h22);
      apb_rd(12'h003, rd);
      check("h2s_underflow_data", rd, 8'h00);
      apb_rd(12'h001, rd);
      check("status_unf", rd, 8'h25);
      apb_wr(12'h001, 8'h20);
      apb_rd(12'h001, rd);
      check("status_unf_clr", rd, 8'h05);

      // Interrupt timing
      apb_wr(12'h000, 8'h01);
      apb_rd(12'h000, rd);
      check("ctrl_rd", rd, 8'h01);
      apb_wr(12'h002, 8'h77);
      check("irq_commit_cycle", irq, 1'b0);
      @(posedge clk); #1;
      check("irq_rise", irq, 1'b1);
      host_pop();
      check("irq_hold", irq, 1'b1);
      @(posedge clk); #1;
      check("irq_fall", irq, 1'b0);

      // H2S full, then flush racing a host push
      for (int i = 0; i < 4; i++) host_push(8'h31 + 8'(i));
      check("h2s_full_ready", tx_ready, 1'b0);
      apb_rd(12'h001, rd);
      check("status_h2s_full", rd, 8'h09);
      apb_rd(12'h003, rd);
      check("h2s_full_rd0", rd, 8'h31);
      apb_rd(12'h003, rd);
      check("h2s_full_rd1", rd, 8'h32);
      psel = 1'b1; penable = 1'b0; paddr = 12'h000; pwrite = 1'b1; pwdata = 8'h04;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      tx_valid = 1'b1; tx_data = 8'h55;
      #3;
      check("flush_commit_pready", pready, 1'b1);
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; tx_valid = 1'b0;
      @(posedge clk); #1;
      apb_rd(12'h001, rd);
      check("status_after_flush", rd, 8'h05);
      apb_rd(12'h000, rd);
      check("ctrl_flush_bits_read0", rd, 8'h00);

      // Scratch, unmapped addresses, full-width decode
      apb_wr(12'h004, 8'h5A);
      apb_rd(12'h004, rd);
      check("scratch_rd", rd, 8'h5A);
      apb(12'h010, 1'b0, 8'h00, rd, cyc);
      check("unmapped_rd", rd, 8'h00);
      check("unmapped_cycles", cyc, 1);
      apb_wr(12'h102, 8'h99);
      check("alias_write_ignored", rx_valid, 1'b0);

      // Reset in the middle of an access
      psel = 1'b1; penable = 1'b0; paddr = 12'h004; pwrite = 1'b0;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      #1;
      check("pre_reset_pready", pready, 1'b1);
      check("pre_reset_prdata", prdata, 8'h5A);
      rst_n = 1'b0;
      #1;
      check("mid_reset_pready", pready, 1'b0);
      check("mid_reset_prdata", prdata, 8'h00);
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      apb_rd(12'h004, rd);
      check("scratch_after_reset", rd, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
